// File: rtl/dm_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_store_buffer_pkg
//  Purpose  : Shared definitions for the DM word-store write buffer:
//             default geometry, DM address window and the entry record.
//  Revision : 1.0  initial release
// ============================================================================
package dm_store_buffer_pkg;

    // Default buffer geometry
    localparam int SB_DEPTH = 4;          // entries (power of 2, >= 2)
    localparam int SB_AW    = 12;         // word-address (tag) width

    // Data-memory address window served through the buffer
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT = 32'h0000_2fff;

    // One buffered store
    typedef struct packed {
        logic              valid;
        logic [SB_AW-1:0]  tag;
        logic [31:0]       data;
    } sb_entry_t;

endpackage : dm_store_buffer_pkg
`default_nettype wire

// File: rtl/sb_tag_match.sv
`default_nettype none
// ============================================================================
//  Module   : sb_tag_match
//  Purpose  : DEPTH-way tag comparator for the store buffer. Produces a
//             one-hot hit vector and the data of the hitting entry.
//  Ports    : valid    - per-entry valid bits
//             tags     - per-entry word tags
//             datas    - per-entry store data
//             tag      - tag being looked up
//             hit_vec  - one-hot hit (tags are unique among valid entries)
//             hit      - any entry hit
//             hit_data - data of the hitting entry, 0 on miss
//  Revision : 1.0  initial release
// ============================================================================
module sb_tag_match
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic [DEPTH-1:0]           valid,
    input  logic [DEPTH-1:0][AW-1:0]   tags,
    input  logic [DEPTH-1:0][31:0]     datas,
    input  logic [AW-1:0]              tag,
    output logic [DEPTH-1:0]           hit_vec,
    output logic                       hit,
    output logic [31:0]                hit_data
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign hit_vec[i] = valid[i] && (tags[i] == tag);
    end

    assign hit = |hit_vec;

    // AND-OR mux: at most one bit of hit_vec is set
    always_comb begin
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) begin
                hit_data = hit_data | datas[i];
            end
        end
    end

endmodule : sb_tag_match
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : dm_store_buffer
//  Purpose  : Word-store write buffer between the M-stage and data memory.
//             Stores enter a small FIFO and drain one per cycle whenever the
//             DM port is not used by a load. Loads forward from the buffer on
//             a tag hit, otherwise return DM read data. Same-word stores
//             coalesce so buffered tags stay unique.
//  Ports    : Clk, reset (async, active-low)
//             req_valid/req_we/req_addr/req_wdata/req_exc - M-stage access
//             fence  - drain request; stall held until the buffer is empty
//             rdata  - combinational load data
//             stall, empty, count - buffer status
//             dm_addr/dm_wd/dm_we - DM port, dm_rd - DM read data
//  Revision : 1.0  initial release
// ============================================================================
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic                        Clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic                        req_we,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    input  logic                        req_exc,
    input  logic                        fence,
    output logic [31:0]                 rdata,
    output logic                        stall,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic [31:0]                 dm_addr,
    output logic [31:0]                 dm_wd,
    output logic                        dm_we,
    input  logic [31:0]                 dm_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]              r_head;
    logic [PW-1:0]              r_tail;
    logic [CW-1:0]              r_count;
    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0][AW-1:0]   r_tag;
    logic [DEPTH-1:0][31:0]     r_data;

    logic                       w_ld;
    logic                       w_st;
    logic                       w_empty;
    logic                       w_drain;
    logic [AW-1:0]              w_tag;
    logic [DEPTH-1:0]           w_hit_vec;
    logic                       w_hit;
    logic [31:0]                w_hit_data;
    logic                       w_head_hit;
    logic                       w_coalesce;
    logic                       w_enq;
    logic                       w_unused_ok;

    assign w_ld    = req_valid & ~req_we & ~req_exc;
    assign w_st    = req_valid &  req_we & ~req_exc;
    assign w_empty = (r_count == '0);
    assign w_tag   = req_addr[AW+1:2];

    // The single DM port belongs to a load when one is present
    assign w_drain = ~w_ld & ~w_empty;

    sb_tag_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .valid    (r_valid),
        .tags     (r_tag),
        .datas    (r_data),
        .tag      (w_tag),
        .hit_vec  (w_hit_vec),
        .hit      (w_hit),
        .hit_data (w_hit_data)
    );

    // A hit on the head that is leaving this cycle cannot be overwritten:
    // the old data goes to DM now and the new data is queued behind it.
    assign w_head_hit = w_hit_vec[r_head];
    assign w_coalesce = w_st & w_hit & ~(w_drain & w_head_hit);
    assign w_enq      = w_st & ~w_coalesce;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_coalesce) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_hit_vec[i]) begin
                        r_data[i] <= req_wdata;
                    end
                end
            end
            // Placed after the drain so a full-buffer enqueue into the slot
            // being vacated (tail == head) wins.
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tag[r_tail]   <= w_tag;
                r_data[r_tail]  <= req_wdata;
                r_tail          <= r_tail + PW'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign empty = w_empty;
    assign stall = fence & ~w_empty;
    assign dm_we = w_drain;

    always_comb begin
        rdata   = '0;
        dm_addr = '0;
        dm_wd   = '0;
        if (reset) begin
            dm_wd = r_data[r_head];
            if (w_ld) begin
                dm_addr = {req_addr[31:2], 2'b00};
                rdata   = w_hit ? w_hit_data : dm_rd;
            end else begin
                dm_addr = {{(30-AW){1'b0}}, r_tag[r_head], 2'b00};
            end
        end
    end

    // Byte-offset bits carry no information for word accesses
    assign w_unused_ok = &{1'b0, req_addr[1:0]};

endmodule : dm_store_buffer
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_store_buffer
//  Purpose  : Self-checking bench for dm_store_buffer: directed vector table,
//             an asynchronous-reset sequence, then randomized traffic checked
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_store_buffer;

    logic        clk;
    logic        reset;
    logic        req_valid, req_we, req_exc, fence;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata, dm_addr, dm_wd, dm_rd;
    logic        stall, empty, dm_we;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    dm_store_buffer #(.DEPTH(4), .AW(12)) dut (
        .Clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_exc   (req_exc),
        .fence     (fence),
        .rdata     (rdata),
        .stall     (stall),
        .empty     (empty),
        .count     (count),
        .dm_addr   (dm_addr),
        .dm_wd     (dm_wd),
        .dm_we     (dm_we),
        .dm_rd     (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory environment: unwritten words read a fixed pattern
    function automatic logic [31:0] init_word(input logic [11:0] t);
        return 32'h5000_0000 | {20'h0, t};
    endfunction

    logic [31:0] dmem [0:4095];
    bit          dwr  [0:4095];
    always @(posedge clk) begin
        if (dm_we) begin
            dmem[dm_addr[13:2]] <= dm_wd;
            dwr[dm_addr[13:2]]  <= 1'b1;
        end
    end
    assign dm_rd = dwr[dm_addr[13:2]] ? dmem[dm_addr[13:2]] : init_word(dm_addr[13:2]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's request at the falling edge; outputs settle by +1
    task automatic step(input logic v, input logic we, input logic exc, input logic fn,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = v; req_we = we; req_exc = exc; fence = fn;
        req_addr = a; req_wdata = wd;
        #1;
    endtask

    typedef struct {
        logic        v, we, exc, fn;
        logic [31:0] addr, wd;
        logic [31:0] e_rdata;
        logic        e_we;
        logic [31:0] e_addr, e_wd;
        int          e_count;
        logic        e_stall;
    } vec_t;

    function automatic vec_t mk(input logic v, we, exc, fn, input logic [31:0] a, wd,
                                input logic [31:0] er, input logic ew,
                                input logic [31:0] ea, ewd, input int ec, input logic es);
        vec_t t;
        t.v = v; t.we = we; t.exc = exc; t.fn = fn; t.addr = a; t.wd = wd;
        t.e_rdata = er; t.e_we = ew; t.e_addr = ea; t.e_wd = ewd;
        t.e_count = ec; t.e_stall = es;
        return t;
    endfunction

    // Reference model: ordered list of buffered words plus DM contents
    typedef struct {
        logic [11:0] tag;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_rd(input logic [11:0] t);
        if (ref_mem.exists(int'(t))) return ref_mem[int'(t)];
        return init_word(t);
    endfunction

    vec_t tbl[$];

    initial begin
        req_valid = 0; req_we = 0; req_exc = 0; fence = 0;
        req_addr = 0; req_wdata = 0;

        // ---- reset state (a load presented during reset must read 0)
        reset = 1'b0;
        req_valid = 1; req_addr = 32'h10;
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_dm_we", 32'(dm_we), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_dm_wd", dm_wd, 0);
        @(negedge clk);
        reset = 1'b1; req_valid = 0;

        // ---- directed table: v we exc fn addr wdata | rdata we addr wd count stall
        tbl.push_back(mk(1,1,0,0,32'h10,32'hAAAA_0001, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,32'h0,         0,1,32'h10,32'hAAAA_0001,1,0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,32'h0,         0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,32'h20,32'h11,        0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,32'h20,32'h0,         32'h11,0,32'h20,0,1,0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,32'h0,         0,1,32'h20,32'h11,1,0));
        tbl.push_back(mk(1,0,0,0,32'h10,32'h0,         32'hAAAA_0001,0,32'h10,0,0,0));
        tbl.push_back(mk(1,1,0,0,32'h40,32'h1,         0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,32'h44,32'h0,         32'h5000_0011,0,32'h44,0,1,0));
        tbl.push_back(mk(1,1,0,0,32'h40,32'h2,         0,1,32'h40,32'h1,1,0));
        tbl.push_back(mk(1,0,0,0,32'h40,32'h0,         32'h2,0,32'h40,0,1,0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,32'h0,         0,1,32'h40,32'h2,1,0));
        tbl.push_back(mk(1,0,0,0,32'h40,32'h0,         32'h2,0,32'h40,0,0,0));
        tbl.push_back(mk(1,1,1,0,32'h80,32'h33,        0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,32'h80,32'h0,         0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,32'h80,32'h0,         32'h5000_0020,0,32'h80,0,0,0));
        tbl.push_back(mk(1,1,0,0,32'h50,32'h55,        0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,32'h54,32'h66,        0,1,32'h50,32'h55,1,0));
        tbl.push_back(mk(0,0,0,1,32'h0 ,32'h0,         0,1,32'h54,32'h66,1,1));
        tbl.push_back(mk(0,0,0,1,32'h0 ,32'h0,         0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,32'h60,32'h7,         0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,32'h64,32'h8,         0,1,32'h60,32'h7,1,0));
        tbl.push_back(mk(0,0,0,0,32'h0 ,32'h0,         0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,32'h64,32'h0,         32'h5000_0019,0,32'h64,0,0,0));

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].we, tbl[i].exc, tbl[i].fn, tbl[i].addr, tbl[i].wd);
            chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("v%0d_dm_we", i), 32'(dm_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_count == 0));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            if (tbl[i].e_we || (tbl[i].v && !tbl[i].we && !tbl[i].exc))
                chk($sformatf("v%0d_dm_addr", i), dm_addr, tbl[i].e_addr);
            if (tbl[i].e_we)
                chk($sformatf("v%0d_dm_wd", i), dm_wd, tbl[i].e_wd);
        end

        // ---- asynchronous reset while a store is draining
        step(1,1,0,0,32'h70,32'h99);
        step(0,0,0,0,32'h0,32'h0);
        chk("pre_rst_dm_we", 32'(dm_we), 1);
        chk("pre_rst_count", 32'(count), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_dm_we", 32'(dm_we), 0);
        chk("mid_rst_dm_wd", dm_wd, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(0,0,0,0,32'h0,32'h0);
            chk("post_rst_dm_we", 32'(dm_we), 0);
        end
        step(1,0,0,0,32'h70,32'h0);
        chk("post_rst_lw", rdata, 32'h5000_001C);

        // ---- randomized traffic against the reference model (words 0x200..0x21C)
        for (int c = 0; c < 400; c++) begin
            logic [31:0] r, a, wd, e_rd;
            logic        v, we, exc, fn, ld, st, drn;
            int          k;
            r   = $urandom;
            v   = (r[1:0] != 2'b00);
            we  = r[2];
            exc = (r[6:3] == 4'h0);
            fn  = !v && r[7];
            a   = 32'h200 + {27'h0, r[10:8], 2'b00} + {30'h0, r[12:11]};
            wd  = $urandom;
            step(v, we, exc, fn, a, wd);

            ld  = v && !we && !exc;
            st  = v && we && !exc;
            drn = !ld && (mq.size() > 0);
            k   = -1;
            foreach (mq[i]) if (mq[i].tag == a[13:2]) k = i;

            e_rd = 0;
            if (ld) e_rd = (k >= 0) ? mq[k].data : ref_rd(a[13:2]);
            chk("rnd_rdata", rdata, e_rd);
            chk("rnd_dm_we", 32'(dm_we), 32'(drn));
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
            chk("rnd_stall", 32'(stall), 32'(fn && mq.size() > 0));
            if (drn) begin
                chk("rnd_dm_addr", dm_addr, {18'h0, mq[0].tag, 2'b00});
                chk("rnd_dm_wd", dm_wd, mq[0].data);
            end else if (ld) begin
                chk("rnd_dm_addr", dm_addr, {a[31:2], 2'b00});
            end

            // state update at the coming clock edge
            if (st && k >= 0 && !(drn && k == 0)) mq[k].data = wd;
            if (drn) begin
                ref_mem[int'(mq[0].tag)] = mq[0].data;
                void'(mq.pop_front());
            end
            if (st && !(k >= 0 && !(drn && k == 0))) begin
                ent_t e;
                e.tag = a[13:2]; e.data = wd;
                mq.push_back(e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dm_store_buffer
`default_nettype wire
